// File: rtl/tt_um_rps_match.sv
// -----------------------------------------------------------------------------
// tt_um_rps_match
//
// Best-of-N rock-paper-scissors match controller for a Tiny Tapeout slot.
// Each player locks a move with a rising edge on its lock strobe. Once both
// moves are held, the round is resolved with a cyclic-dominance rule over
// NUM_MOVES moves; scores and a consecutive-tie count are tracked until one
// player reaches WINS_NEEDED or MAX_TIES non-decisive rounds occur in a row.
//
// Parameters
//   NUM_MOVES      odd, 3..7   legal moves are 0..NUM_MOVES-1
//   WINS_NEEDED    1..7        score that ends the match
//   MAX_TIES       1..15       consecutive non-decisive rounds for a draw
//   TIMEOUT_CYCLES 1..65535    single-capture wait limit (timeout build only)
//
// Ports
//   clk      in   clock
//   rst_n    in   asynchronous active-low reset
//   ena      in   slot enable; low freezes all state and edge detectors
//   ui_in    in   [2:0] P1 move, [5:3] P2 move, [6] P1 lock, [7] P2 lock
//   uio_in   in   [0] new_match; other bits ignored
//   uo_out   out  [1:0] last round result (00 tie, 01 P1, 10 P2, 11 both
//                 invalid), [2] round_done pulse, [3] P1 captured,
//                 [4] P2 captured, [6:5] match result (00 running, 01 P1,
//                 10 P2, 11 draw), [7] match_over
//   uio_out  out  [0] 0, [3:1] P1 score, [6:4] P2 score,
//                 [7] last round decided by timeout
//   uio_oe   out  constant 8'hFE
//
// Build option
//   RPS_LOCK_TIMEOUT_EN  when defined, a round with only one captured player
//                        is resolved in that player's favour after
//                        TIMEOUT_CYCLES enabled cycles.
// -----------------------------------------------------------------------------
module tt_um_rps_match #(
   parameter int NUM_MOVES      = 3,
   parameter int WINS_NEEDED    = 2,
   parameter int MAX_TIES       = 7,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // Stop elaboration of a configuration the datapath widths cannot hold.
   if (NUM_MOVES < 3 || NUM_MOVES > 7 || (NUM_MOVES % 2) == 0 ||
       WINS_NEEDED < 1 || WINS_NEEDED > 7 || MAX_TIES < 1 || MAX_TIES > 15 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
      $error("tt_um_rps_match: parameter out of range");
   end

   localparam logic [3:0] NM_L   = 4'(NUM_MOVES);
   localparam logic [3:0] HALF_L = 4'((NUM_MOVES - 1) / 2);
   localparam logic [2:0] WINS_L = 3'(WINS_NEEDED);
   localparam logic [3:0] TIES_L = 4'(MAX_TIES);

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_RESOLVE = 2'd1,
      ST_OVER    = 2'd2
   } state_e;

   // Round outcome for two held moves; an invalid move forfeits to the other
   // player and two invalid moves give the "no contest" code 11.
   function automatic logic [1:0] resolve_round(input logic [2:0] m1,
                                                input logic [2:0] m2);
      logic       v1;
      logic       v2;
      logic [3:0] d;
      logic [1:0] r;
      v1 = ({1'b0, m1} < NM_L);
      v2 = ({1'b0, m2} < NM_L);
      // (m1 - m2) mod NUM_MOVES without a divider: bias by NUM_MOVES first.
      d  = {1'b0, m1} + NM_L - {1'b0, m2};
      if (d >= NM_L) begin
         d = d - NM_L;
      end else begin
         d = d;
      end
      if (!v1 && !v2) begin
         r = 2'b11;
      end else if (!v1) begin
         r = 2'b10;
      end else if (!v2) begin
         r = 2'b01;
      end else if (d == 4'd0) begin
         r = 2'b00;
      end else if (d <= HALF_L) begin
         r = 2'b01;
      end else begin
         r = 2'b10;
      end
      return r;
   endfunction

   // Outcome of a timed-out round: the lone captured player wins if its move
   // is legal, otherwise the round is a no contest.
   function automatic logic [1:0] timeout_round(input logic       p1_held,
                                                input logic [2:0] m1,
                                                input logic [2:0] m2);
      logic [1:0] r;
      if (p1_held) begin
         r = ({1'b0, m1} < NM_L) ? 2'b01 : 2'b11;
      end else begin
         r = ({1'b0, m2} < NM_L) ? 2'b10 : 2'b11;
      end
      return r;
   endfunction

   state_e     state_q,      state_d;
   logic       p1_prev_q,    p1_prev_d;
   logic       p2_prev_q,    p2_prev_d;
   logic       nm_prev_q,    nm_prev_d;
   logic [2:0] p1_move_q,    p1_move_d;
   logic [2:0] p2_move_q,    p2_move_d;
   logic       p1_cap_q,     p1_cap_d;
   logic       p2_cap_q,     p2_cap_d;
   logic [1:0] result_q,     result_d;
   logic       round_done_q, round_done_d;
   logic [1:0] match_res_q,  match_res_d;
   logic       over_q,       over_d;
   logic [2:0] p1_score_q,   p1_score_d;
   logic [2:0] p2_score_q,   p2_score_d;
   logic [3:0] tie_cnt_q,    tie_cnt_d;
   logic       tmo_flag_q,   tmo_flag_d;

   logic       p1_edge_s;
   logic       p2_edge_s;
   logic       nm_edge_s;
   logic       round_tmo_s;
   logic [1:0] round_res_s;
   logic       unused_s;

`ifdef RPS_LOCK_TIMEOUT_EN
   localparam logic [15:0] TMO_L = 16'(TIMEOUT_CYCLES);
   logic [15:0] tmo_cnt_q,  tmo_cnt_d;
   logic        tmo_pend_q, tmo_pend_d;
   assign round_tmo_s = tmo_pend_q;
`else
   assign round_tmo_s = 1'b0;
`endif

   assign unused_s = &{1'b0, uio_in[7:1]};

   // Edges only count in enabled cycles; the previous-value registers hold
   // while ena is low so nothing is replayed afterwards unless still high.
   assign p1_edge_s = ena & ui_in[6]  & ~p1_prev_q;
   assign p2_edge_s = ena & ui_in[7]  & ~p2_prev_q;
   assign nm_edge_s = ena & uio_in[0] & ~nm_prev_q;

   assign round_res_s = round_tmo_s ? timeout_round(p1_cap_q, p1_move_q, p2_move_q)
                                    : resolve_round(p1_move_q, p2_move_q);

   // Next-state logic for the match FSM, scoreboard and edge detectors.
   always_comb begin
      state_d      = state_q;
      p1_prev_d    = p1_prev_q;
      p2_prev_d    = p2_prev_q;
      nm_prev_d    = nm_prev_q;
      p1_move_d    = p1_move_q;
      p2_move_d    = p2_move_q;
      p1_cap_d     = p1_cap_q;
      p2_cap_d     = p2_cap_q;
      result_d     = result_q;
      round_done_d = round_done_q;
      match_res_d  = match_res_q;
      over_d       = over_q;
      p1_score_d   = p1_score_q;
      p2_score_d   = p2_score_q;
      tie_cnt_d    = tie_cnt_q;
      tmo_flag_d   = tmo_flag_q;
`ifdef RPS_LOCK_TIMEOUT_EN
      tmo_cnt_d    = tmo_cnt_q;
      tmo_pend_d   = tmo_pend_q;
`endif

      if (ena) begin
         p1_prev_d    = ui_in[6];
         p2_prev_d    = ui_in[7];
         nm_prev_d    = uio_in[0];
         round_done_d = 1'b0;

         if (nm_edge_s) begin
            // new_match wins over any lock edge in the same cycle.
            state_d     = ST_COLLECT;
            p1_cap_d    = 1'b0;
            p2_cap_d    = 1'b0;
            result_d    = 2'b00;
            match_res_d = 2'b00;
            over_d      = 1'b0;
            p1_score_d  = 3'd0;
            p2_score_d  = 3'd0;
            tie_cnt_d   = 4'd0;
            tmo_flag_d  = 1'b0;
`ifdef RPS_LOCK_TIMEOUT_EN
            tmo_cnt_d   = 16'd0;
            tmo_pend_d  = 1'b0;
`endif
         end else begin
            case (state_q)
               ST_COLLECT: begin
                  // First edge per player wins; later re-locks are ignored.
                  if (p1_edge_s && !p1_cap_q) begin
                     p1_move_d = ui_in[2:0];
                     p1_cap_d  = 1'b1;
                  end else begin
                     p1_move_d = p1_move_q;
                  end
                  if (p2_edge_s && !p2_cap_q) begin
                     p2_move_d = ui_in[5:3];
                     p2_cap_d  = 1'b1;
                  end else begin
                     p2_move_d = p2_move_q;
                  end

                  if (p1_cap_d && p2_cap_d) begin
                     state_d = ST_RESOLVE;
`ifdef RPS_LOCK_TIMEOUT_EN
                     tmo_cnt_d = 16'd0;
                  end else if (p1_cap_q ^ p2_cap_q) begin
                     // Counts enabled cycles spent waiting on the second player.
                     tmo_cnt_d = tmo_cnt_q + 16'd1;
                     if (tmo_cnt_d == TMO_L) begin
                        state_d    = ST_RESOLVE;
                        tmo_pend_d = 1'b1;
                     end else begin
                        state_d    = ST_COLLECT;
                     end
`endif
                  end else begin
                     state_d = ST_COLLECT;
                  end
               end

               ST_RESOLVE: begin
                  result_d     = round_res_s;
                  round_done_d = 1'b1;
                  tmo_flag_d   = round_tmo_s;
                  p1_cap_d     = 1'b0;
                  p2_cap_d     = 1'b0;
`ifdef RPS_LOCK_TIMEOUT_EN
                  tmo_cnt_d    = 16'd0;
                  tmo_pend_d   = 1'b0;
`endif
                  case (round_res_s)
                     2'b01: begin
                        p1_score_d = (p1_score_q < WINS_L) ? p1_score_q + 3'd1 : p1_score_q;
                        tie_cnt_d  = 4'd0;
                     end
                     2'b10: begin
                        p2_score_d = (p2_score_q < WINS_L) ? p2_score_q + 3'd1 : p2_score_q;
                        tie_cnt_d  = 4'd0;
                     end
                     default: begin
                        tie_cnt_d  = (tie_cnt_q < TIES_L) ? tie_cnt_q + 4'd1 : tie_cnt_q;
                     end
                  endcase

                  if (p1_score_d == WINS_L) begin
                     state_d     = ST_OVER;
                     match_res_d = 2'b01;
                     over_d      = 1'b1;
                  end else if (p2_score_d == WINS_L) begin
                     state_d     = ST_OVER;
                     match_res_d = 2'b10;
                     over_d      = 1'b1;
                  end else if (tie_cnt_d == TIES_L) begin
                     state_d     = ST_OVER;
                     match_res_d = 2'b11;
                     over_d      = 1'b1;
                  end else begin
                     state_d     = ST_COLLECT;
                  end
               end

               ST_OVER: begin
                  state_d = ST_OVER;
               end

               default: begin
                  state_d = ST_COLLECT;
               end
            endcase
         end
      end else begin
         state_d = state_q;
      end
   end

   // All state registers; reset clears everything and drops any open round.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_COLLECT;
         p1_prev_q    <= 1'b0;
         p2_prev_q    <= 1'b0;
         nm_prev_q    <= 1'b0;
         p1_move_q    <= 3'd0;
         p2_move_q    <= 3'd0;
         p1_cap_q     <= 1'b0;
         p2_cap_q     <= 1'b0;
         result_q     <= 2'b00;
         round_done_q <= 1'b0;
         match_res_q  <= 2'b00;
         over_q       <= 1'b0;
         p1_score_q   <= 3'd0;
         p2_score_q   <= 3'd0;
         tie_cnt_q    <= 4'd0;
         tmo_flag_q   <= 1'b0;
`ifdef RPS_LOCK_TIMEOUT_EN
         tmo_cnt_q    <= 16'd0;
         tmo_pend_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         p1_prev_q    <= p1_prev_d;
         p2_prev_q    <= p2_prev_d;
         nm_prev_q    <= nm_prev_d;
         p1_move_q    <= p1_move_d;
         p2_move_q    <= p2_move_d;
         p1_cap_q     <= p1_cap_d;
         p2_cap_q     <= p2_cap_d;
         result_q     <= result_d;
         round_done_q <= round_done_d;
         match_res_q  <= match_res_d;
         over_q       <= over_d;
         p1_score_q   <= p1_score_d;
         p2_score_q   <= p2_score_d;
         tie_cnt_q    <= tie_cnt_d;
         tmo_flag_q   <= tmo_flag_d;
`ifdef RPS_LOCK_TIMEOUT_EN
         tmo_cnt_q    <= tmo_cnt_d;
         tmo_pend_q   <= tmo_pend_d;
`endif
      end
   end

   assign uo_out  = {over_q, match_res_q, p2_cap_q, p1_cap_q, round_done_q, result_q};
   assign uio_out = {tmo_flag_q, p2_score_q, p1_score_q, 1'b0};
   assign uio_oe  = 8'hFE;

endmodule

// File: tb/tb_tt_um_rps_match.sv
module tb_tt_um_rps_match;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena_s  [3];
   logic [7:0] ui_s   [3];
   logic [7:0] uioi_s [3];
   logic [7:0] uo_s   [3];
   logic [7:0] uioo_s [3];
   logic [7:0] oe_s   [3];
   int         total = 0;
   int         bad   = 0;

   always #5 clk = ~clk;

   // 0: default build, 1: MAX_TIES=3, 2: NUM_MOVES=5 with a short timeout
   tt_um_rps_match u_dut0 (
      .clk(clk), .rst_n(rst_n), .ena(ena_s[0]), .ui_in(ui_s[0]), .uio_in(uioi_s[0]),
      .uo_out(uo_s[0]), .uio_out(uioo_s[0]), .uio_oe(oe_s[0]));
   tt_um_rps_match #(.MAX_TIES(3)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .ena(ena_s[1]), .ui_in(ui_s[1]), .uio_in(uioi_s[1]),
      .uo_out(uo_s[1]), .uio_out(uioo_s[1]), .uio_oe(oe_s[1]));
   tt_um_rps_match #(.NUM_MOVES(5), .TIMEOUT_CYCLES(10)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .ena(ena_s[2]), .ui_in(ui_s[2]), .uio_in(uioi_s[2]),
      .uo_out(uo_s[2]), .uio_out(uioo_s[2]), .uio_oe(oe_s[2]));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   // Both locks rise together with the given moves, then drop; returns at the
   // cycle where the round result is visible.
   task automatic play(input int k, input logic [2:0] m1, input logic [2:0] m2);
      ui_s[k] = {2'b11, m2, m1};
      step();
      ui_s[k] = {2'b00, m2, m1};
      step();
   endtask

   task automatic new_match(input int k);
      uioi_s[k] = 8'h01;
      step();
      uioi_s[k] = 8'h00;
      step();
   endtask

   // Hard stop in case anything above ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---- reset with random inputs ----
      rst_n = 1'b0;
      for (int k = 0; k < 3; k++) begin
         ena_s[k]  = 1'b1;
         ui_s[k]   = 8'($urandom);
         uioi_s[k] = 8'($urandom) & 8'hFE;
      end
      step(); step(); step();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_uo%0d", k), uo_s[k], 8'h00);
         chk($sformatf("rst_uio%0d", k), uioo_s[k], 8'h00);
         chk($sformatf("rst_oe%0d", k), oe_s[k], 8'hFE);
         ui_s[k]   = 8'h00;
         uioi_s[k] = 8'h00;
      end
      step();
      rst_n = 1'b1;
      step();
      chk("post_rst_uo", uo_s[0], 8'h00);
      chk("post_rst_oe", oe_s[0], 8'hFE);

      // ---- DUT0: P1 (1) beats P2 (0) twice -> match to P1 ----
      play(0, 3'd1, 3'd0);
      chk("r1_uo", uo_s[0], 8'h05);
      chk("r1_uio", uioo_s[0], 8'h02);
      play(0, 3'd1, 3'd0);
      chk("r2_uo", uo_s[0], 8'hA5);
      chk("r2_uio", uioo_s[0], 8'h04);
      step();
      chk("over_pulse_gone", uo_s[0], 8'hA1);
      play(0, 3'd0, 3'd1);
      chk("over_ignores_uo", uo_s[0], 8'hA1);
      chk("over_ignores_uio", uioo_s[0], 8'h04);
      new_match(0);
      chk("nm_uo", uo_s[0], 8'h00);
      chk("nm_uio", uioo_s[0], 8'h00);

      // ---- DUT0: first capture kept, latency two cycles after P2 edge ----
      ui_s[0] = 8'h42; step();
      chk("p1_cap", uo_s[0], 8'h08);
      ui_s[0] = 8'h02; step();
      step();
      ui_s[0] = 8'h40; step();
      ui_s[0] = 8'h00; step();
      chk("relock_ignored", uo_s[0], 8'h08);
      ui_s[0] = 8'h80; step();
      chk("resolve_cycle", uo_s[0], 8'h18);
      ui_s[0] = 8'h00; step();
      chk("keep_first_uo", uo_s[0], 8'h06);
      chk("keep_first_uio", uioo_s[0], 8'h10);

      // ---- DUT0: forfeit and double-invalid ----
      play(0, 3'd0, 3'd3);
      chk("forfeit_uo", uo_s[0], 8'h05);
      chk("forfeit_uio", uioo_s[0], 8'h12);
      play(0, 3'd3, 3'd7);
      chk("both_inv_uo", uo_s[0], 8'h07);
      chk("both_inv_uio", uioo_s[0], 8'h12);

      // ---- DUT0: ena low freezes an in-flight RESOLVE ----
      new_match(0);
      ui_s[0] = 8'hC1; step();
      ena_s[0] = 1'b0;
      ui_s[0] = 8'h01;
      step(); step(); step();
      chk("frozen_uo", uo_s[0], 8'h18);
      chk("frozen_uio", uioo_s[0], 8'h00);
      ena_s[0] = 1'b1; step();
      chk("thaw_uo", uo_s[0], 8'h05);
      chk("thaw_uio", uioo_s[0], 8'h02);
      // an edge that comes and goes while disabled is never seen
      ena_s[0] = 1'b0;
      ui_s[0] = 8'h41; step();
      ui_s[0] = 8'h01; step();
      ena_s[0] = 1'b1; step();
      chk("hidden_edge", uo_s[0], 8'h01);

      // ---- DUT1 (MAX_TIES=3): three ties -> draw ----
      play(1, 3'd1, 3'd1);
      chk("tie1_uo", uo_s[1], 8'h04);
      play(1, 3'd1, 3'd1);
      play(1, 3'd1, 3'd1);
      chk("draw_uo", uo_s[1], 8'hE4);
      chk("draw_uio", uioo_s[1], 8'h00);
      uioi_s[1] = 8'h01;
      ui_s[1]   = 8'h41;
      step();
      chk("nm_prio_uo", uo_s[1], 8'h00);
      chk("nm_prio_uio", uioo_s[1], 8'h00);
      uioi_s[1] = 8'h00;
      ui_s[1]   = 8'h00;
      step();
      chk("nm_prio_hold", uo_s[1], 8'h00);

      // ---- DUT2 (NUM_MOVES=5) ----
      play(2, 3'd0, 3'd3);
      chk("nm5_d2_uo", uo_s[2], 8'h05);
      chk("nm5_d2_uio", uioo_s[2], 8'h02);
      play(2, 3'd0, 3'd2);
      chk("nm5_d3_uo", uo_s[2], 8'h06);
      chk("nm5_d3_uio", uioo_s[2], 8'h12);
      play(2, 3'd4, 3'd0);
      chk("nm5_p2match_uo", uo_s[2], 8'hC6);
      chk("nm5_p2match_uio", uioo_s[2], 8'h22);
      new_match(2);

      // ---- reset asserted during RESOLVE ----
      ui_s[2] = 8'hC1; step();
      chk("pre_rst_resolve", uo_s[2], 8'h18);
      ui_s[2] = 8'h01;
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_uo", uo_s[2], 8'h00);
      chk("rst_mid_uio", uioo_s[2], 8'h00);
      chk("rst_mid_oe", oe_s[2], 8'hFE);
      step();
      rst_n = 1'b1;
      step();
      chk("rst_mid_after", uioo_s[2], 8'h00);

      // ---- single capture: timeout build resolves, default build waits ----
      ui_s[2] = 8'h41; step();
      chk("lone_cap", uo_s[2], 8'h08);
      ui_s[2] = 8'h01;
`ifdef RPS_LOCK_TIMEOUT_EN
      begin
         int  n;
         logic seen;
         n = 0;
         while (uo_s[2][2] !== 1'b1 && n < 40) begin
            step();
            n++;
         end
         seen = (n < 40);
         chk("tmo_seen", {7'd0, seen}, 8'h01);
         chk("tmo_uo", uo_s[2], 8'h05);
         chk("tmo_uio", uioo_s[2], 8'h82);
      end
`else
      repeat (30) step();
      chk("no_tmo_uo", uo_s[2], 8'h08);
      chk("no_tmo_uio", uioo_s[2], 8'h00);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
